// File: rtl/ahbl_pkg.sv
// Shared AHB-Lite encodings: HTRANS transfer types, HSIZE codes and HRESP values.
// No ports; imported by the bridge and its strobe generator.
package ahbl_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

endpackage

// File: rtl/apb_strb_gen.sv
// APB write strobe generator from AHB size and low address bits.
// Ports: size_i (HSIZE), addr_i (HADDR[1:0]), write_i; strb_o is 0 for reads.
module apb_strb_gen
    import ahbl_pkg::*;
(
    input  logic [2:0] size_i,
    input  logic [1:0] addr_i,
    input  logic       write_i,
    output logic [3:0] strb_o
);

    always_comb begin
        strb_o = 4'b0000;
        if (write_i) begin
            unique case (1'b1)
                (size_i == HSIZE_BYTE): strb_o = 4'b0001 << addr_i;
                // Halfword lanes ignore addr bit 0: misaligned halves truncate.
                (size_i == HSIZE_HALF): strb_o = 4'b0011 << {addr_i[1], 1'b0};
                default:                strb_o = 4'b1111;
            endcase
        end
    end

endmodule

// File: rtl/ahbl_apb_bridge.sv
// AHB-Lite slave to APB bridge for four peripherals, one outstanding transfer.
// Ports: AHB-Lite slave side (HSEL..HRESP) and APB master side (PADDR..PSLVERR).
module ahbl_apb_bridge
    import ahbl_pkg::*;
#(
    parameter int PSEL_LSB = 16,
    parameter int TIMEOUT  = 255
) (
    input  logic         HCLK,
    input  logic         HRESETn,
    input  logic         HSEL,
    input  logic [31:0]  HADDR,
    input  logic [1:0]   HTRANS,
    input  logic         HWRITE,
    input  logic [2:0]   HSIZE,
    input  logic [31:0]  HWDATA,
    input  logic         HREADY,
    output logic         HREADYOUT,
    output logic [31:0]  HRDATA,
    output logic         HRESP,
    output logic [31:0]  PADDR,
    output logic [3:0]   PSEL,
    output logic         PENABLE,
    output logic         PWRITE,
    output logic [31:0]  PWDATA,
    output logic [3:0]   PSTRB,
    input  logic [127:0] PRDATA,
    input  logic [3:0]   PREADY,
    input  logic [3:0]   PSLVERR
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t      state_q;
    logic [1:0]  idx_q;
    logic [7:0]  cnt_q;
    logic        hreadyout_q;
    logic        hresp_q;
    logic [31:0] hrdata_q;
    logic [31:0] paddr_q;
    logic [3:0]  psel_q;
    logic        penable_q;
    logic        pwrite_q;
    logic [31:0] pwdata_q;
    logic [3:0]  pstrb_q;

    logic [3:0]  strb;
    logic [1:0]  hidx;
    logic        capture;
    logic        sel_ready;
    logic        sel_err;
    logic [31:0] sel_rdata;
    logic        tmo_hit;
    logic        unused_htrans0;

    assign unused_htrans0 = HTRANS[0];

    apb_strb_gen u_strb (
        .size_i  (HSIZE),
        .addr_i  (HADDR[1:0]),
        .write_i (HWRITE),
        .strb_o  (strb)
    );

    assign hidx    = HADDR[PSEL_LSB +: 2];
    assign capture = HSEL && HTRANS[1] && HREADY &&
                     (state_q == S_IDLE || state_q == S_ERR2);

    assign sel_ready = PREADY[idx_q];
    assign sel_err   = PSLVERR[idx_q];
    assign sel_rdata = PRDATA[{idx_q, 5'd0} +: 32];

    // Fires on the TIMEOUT-th ACCESS cycle without PREADY.
    assign tmo_hit = (TIMEOUT != 0) &&
                     (({1'b0, cnt_q} + 9'd1) == 9'(TIMEOUT));

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= S_IDLE;
            idx_q       <= 2'd0;
            cnt_q       <= 8'd0;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
            hrdata_q    <= 32'd0;
            paddr_q     <= 32'd0;
            psel_q      <= 4'd0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= 32'd0;
            pstrb_q     <= 4'd0;
        end else begin
            unique case (state_q)
                S_IDLE, S_ERR2: begin
                    if (capture) begin
                        state_q     <= S_SETUP;
                        idx_q       <= hidx;
                        paddr_q     <= {HADDR[31:2], 2'b00};
                        pwrite_q    <= HWRITE;
                        pstrb_q     <= strb;
                        psel_q      <= 4'b0001 << hidx;
                        hreadyout_q <= 1'b0;
                        hresp_q     <= HRESP_OKAY;
                    end else begin
                        state_q     <= S_IDLE;
                        hreadyout_q <= 1'b1;
                        hresp_q     <= HRESP_OKAY;
                    end
                end
                S_SETUP: begin
                    // HWDATA is only valid in the AHB data phase.
                    if (pwrite_q) begin
                        pwdata_q <= HWDATA;
                    end
                    penable_q <= 1'b1;
                    cnt_q     <= 8'd0;
                    state_q   <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (sel_ready) begin
                        psel_q    <= 4'd0;
                        penable_q <= 1'b0;
                        if (sel_err) begin
                            state_q <= S_ERR1;
                            hresp_q <= HRESP_ERROR;
                        end else begin
                            state_q     <= S_IDLE;
                            hreadyout_q <= 1'b1;
                            if (!pwrite_q) begin
                                hrdata_q <= sel_rdata;
                            end
                        end
                    end else if (tmo_hit) begin
                        psel_q    <= 4'd0;
                        penable_q <= 1'b0;
                        state_q   <= S_ERR1;
                        hresp_q   <= HRESP_ERROR;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                S_ERR1: begin
                    hreadyout_q <= 1'b1;
                    state_q     <= S_ERR2;
                end
                default: begin
                    state_q     <= S_IDLE;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= HRESP_OKAY;
                end
            endcase
        end
    end

    assign HREADYOUT = hreadyout_q;
    assign HRESP     = hresp_q;
    assign HRDATA    = hrdata_q;
    assign PADDR     = paddr_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PWDATA    = pwdata_q;
    assign PSTRB     = pstrb_q;

endmodule

// File: doc/ahbl_apb_bridge.md
# ahbl_apb_bridge

AHB-Lite slave that converts single AHB-Lite transfers into APB transfers for up to four peripherals. It hangs off one slave port of the SoC AHB-Lite splitter, receiving that port's HSEL and returning HREADYOUT/HRDATA to it. Behind it sits the low-bandwidth peripheral page (GPIO, UART, timers). One outstanding transfer; the AHB data phase is stretched until the APB access completes, errors, or times out.

## Interface
Parameters:
- PSEL_LSB, 16, HADDR bit position of the 2-bit APB slave index (HADDR[PSEL_LSB+1:PSEL_LSB])
- TIMEOUT, 255, maximum ACCESS cycles waiting for PREADY before an error response; 0 disables, max 255

Ports:
- HCLK  in  1  clock; all logic on rising edge
- HRESETn  in  1  reset, asynchronous assert, active-low
- HSEL  in  1  slave select from splitter
- HADDR  in  32  AHB address
- HTRANS  in  2  AHB transfer type (only bit 1 examined)
- HWRITE  in  1  1 = write
- HSIZE  in  3  0 byte, 1 half, 2 word; others treated as word
- HWDATA  in  32  write data (data phase)
- HREADY  in  1  bus-level ready from splitter
- HREADYOUT  out  1  this slave's ready
- HRDATA  out  32  read data, registered
- HRESP  out  1  1 = ERROR
- PADDR  out  32  APB address (HADDR passed through, bits [1:0] forced 0)
- PSEL  out  4  one-hot APB select
- PENABLE  out  1  APB access phase
- PWRITE  out  1  APB direction
- PWDATA  out  32  APB write data
- PSTRB  out  4  byte strobes; 0 for reads
- PRDATA  in  128  four 32-bit read buses, slave n at [32n+31:32n]
- PREADY  in  4  per-slave ready
- PSLVERR  in  4  per-slave error

## Operation
- Capture condition: HSEL & HTRANS[1] & HREADY while state is IDLE or ERR2. Latch HADDR, HWRITE, HSIZE, slave index. Otherwise ignored (IDLE/BUSY never start a transfer).
- States: IDLE, SETUP, ACCESS, ERR1, ERR2.
- IDLE: HREADYOUT=1, HRESP=0, PSEL=0, PENABLE=0. Capture -> SETUP.
- SETUP: latch HWDATA into PWDATA (write). PSEL[idx]=1, PENABLE=0, HREADYOUT=0. Always -> ACCESS.
- ACCESS: PENABLE=1, HREADYOUT=0. Timeout counter increments each cycle.
  - PREADY[idx]=1, PSLVERR[idx]=0 -> IDLE; HRDATA <= PRDATA slice (reads only, writes leave HRDATA unchanged).
  - PREADY[idx]=1, PSLVERR[idx]=1 -> ERR1.
  - PREADY[idx]=0 and counter reaches TIMEOUT (TIMEOUT!=0) -> ERR1; PSEL/PENABLE drop.
- ERR1: HRESP=1, HREADYOUT=0, PSEL=0. -> ERR2.
- ERR2: HRESP=1, HREADYOUT=1. Capture -> SETUP, else -> IDLE.
- PSEL/PENABLE deassert on leaving ACCESS. PADDR/PWRITE/PSTRB/PWDATA hold last values between transfers.
- PSTRB (write): HSIZE 0 -> 4'b0001<<HADDR[1:0]; 1 -> 4'b0011<<{HADDR[1],1'b0}; else 4'b1111.
- Misaligned half/word: address bits truncated, no error.
- Reset: all outputs 0 except HREADYOUT=1; state IDLE; counter 0.
- Reset mid-transfer aborts immediately; no APB completion is owed.

## Timing
- Zero-wait APB: data phase lasts 3 HCLK cycles (SETUP, ACCESS, IDLE with HREADYOUT=1); 2 AHB wait states. Each PREADY-low cycle adds 1.
- Back-to-back: next address phase is accepted in the completing cycle; SETUP follows on the next edge with no idle gap.
- Error: two-cycle AHB ERROR response (ERR1 HREADYOUT=0, ERR2 HREADYOUT=1), HRESP=1 in both cycles.
- Timeout: with PREADY stuck low, ERR1 is entered after exactly TIMEOUT ACCESS cycles.
- HRDATA is valid in the cycle HREADYOUT returns high after a read; held until the next read completes.
- PREADY/PSLVERR/PRDATA of unselected slaves are ignored.

## Structure
- Shared package/header ahbl_pkg: HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ), HSIZE codes, HRESP OKAY/ERROR.
- Bridge FSM state encoding stays local.
- Sub-module apb_strb_gen (HSIZE, HADDR[1:0], HWRITE -> PSTRB), combinational.

## Test plan
- Reset: HRESETn low mid-ACCESS -> PSEL=0, PENABLE=0, HREADYOUT=1, HRESP=0 immediately.
- Word write 0xDEADBEEF to 0x4002_0008, PREADY=1 -> PSEL=4'b0100, PADDR=0x4002_0008, PSTRB=4'hF, PWDATA=0xDEADBEEF; 2 wait states.
- Byte write to 0x4001_0003 -> PSTRB=4'b1000. Halfword write to 0x4001_0002 -> PSTRB=4'b1100.
- Read from slave 3, PREADY low 3 cycles, PRDATA[127:96]=0x1234_5678 -> 5 wait states; HRDATA=0x1234_5678.
- PSLVERR=1 on completion -> HRESP=1 for 2 cycles, HREADYOUT 0 then 1; back-to-back NONSEQ during ERR2 starts SETUP next cycle.
- TIMEOUT=4, PREADY stuck 0 -> ERR1 after 4 ACCESS cycles, PENABLE drops; with TIMEOUT=0, no error after 1000 cycles.
